wb_result_fifo: RTL and testbench



---
 rtl/wb_result_fifo_if.sv | 28 ++
 rtl/wb_result_fifo.sv | 91 +++++++++
 tb/tb_wb_result_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_result_fifo_if.sv
// Result-buffer handshake bundle: EU-side push channel plus writeback-side head channel.
// The master modport is the buffer itself; slave is the EU/arbiter environment around it.
interface wb_result_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CID_W  = 3
);
  logic              in_valid;
  logic [DATA_W-1:0] in_wdata;
  logic [ADDR_W-1:0] in_waddr;
  logic [CID_W-1:0]  in_commit_id;
  logic              in_ready;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic [ADDR_W-1:0] reg_waddr;
  logic [CID_W-1:0]  commit_id;
  logic              wb_ready;

  modport master (
    input  in_valid, in_wdata, in_waddr, in_commit_id, wb_ready,
    output in_ready, reg_we, reg_wdata, reg_waddr, commit_id
  );

  modport slave (
    output in_valid, in_wdata, in_waddr, in_commit_id, wb_ready,
    input  in_ready, reg_we, reg_wdata, reg_waddr, commit_id
  );
endinterface

// File: rtl/wb_result_fifo.sv
// In-order result buffer between an EU result stage and the writeback arbiter.
// Optional WB_FIFO_BYPASS_EN: when empty, the incoming result is presented in the same cycle.
module wb_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CID_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  wb_result_fifo_if.master         bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [CID_W-1:0]  cid_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             head_valid;
  logic             push, pop;

  assign wr_idx  = wr_ptr_reg[IDX_W-1:0];
  assign rd_idx  = rd_ptr_reg[IDX_W-1:0];
  assign empty_o = (wr_ptr_reg == rd_ptr_reg);
  assign full_o  = (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]) && (wr_idx == rd_idx);
  assign count_o = wr_ptr_reg - rd_ptr_reg;

  // Ready is a function of occupancy only, so the arbiter's ready can never loop back into it.
  assign bus.in_ready = !full_o;
  assign head_valid   = !empty_o && valid_reg[rd_idx];

  always_comb begin
    bus.reg_we    = head_valid;
    bus.reg_wdata = head_valid ? data_mem[rd_idx] : '0;
    bus.reg_waddr = head_valid ? addr_mem[rd_idx] : '0;
    bus.commit_id = head_valid ? cid_mem[rd_idx]  : '0;
    push          = bus.in_valid && !full_o && !flush_i;
    pop           = head_valid && bus.wb_ready;
`ifdef WB_FIFO_BYPASS_EN
    // Empty buffer: offer the incoming result directly; it is stored only if not taken.
    if (empty_o) begin
      bus.reg_we    = bus.in_valid && !flush_i;
      bus.reg_wdata = (bus.in_valid && !flush_i) ? bus.in_wdata     : '0;
      bus.reg_waddr = (bus.in_valid && !flush_i) ? bus.in_waddr     : '0;
      bus.commit_id = (bus.in_valid && !flush_i) ? bus.in_commit_id : '0;
      push          = bus.in_valid && !flush_i && !bus.wb_ready;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_next[gi] = flush_i ? 1'b0 :
        ((valid_reg[gi] && !(pop && rd_idx == IDX_W'(gi))) || (push && wr_idx == IDX_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: outputs are gated by head_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_idx] <= bus.in_wdata;
      addr_mem[wr_idx] <= bus.in_waddr;
      cid_mem[wr_idx]  <= bus.in_commit_id;
    end
  end
endmodule

// File: tb/tb_wb_result_fifo.sv
// Directed bench for wb_result_fifo: vector table for fill/drain plus hand sequences for
// wrap, flush, asynchronous reset and (when built with WB_FIFO_BYPASS_EN) the bypass path.
module tb_wb_result_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       full, empty;

  wb_result_fifo_if #(.DATA_W(32), .ADDR_W(5), .CID_W(3)) bus ();

  wb_result_fifo #(.DEPTH(4), .DATA_W(32), .ADDR_W(5), .CID_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus.master),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        flush, in_valid, wb_ready;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic [2:0]  cid;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [4:0]  exp_waddr;
    logic [2:0]  exp_cid;
    int          exp_count;
    logic        exp_full, exp_empty, exp_ready;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] wd, logic [4:0] wa, logic [2:0] id,
                              logic wr, logic ewe, logic [31:0] ewd, logic [4:0] ewa,
                              logic [2:0] eid, int ecnt, logic efull, logic eempty, logic erdy);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.wdata = wd; v.waddr = wa; v.cid = id; v.wb_ready = wr;
    v.exp_we = ewe; v.exp_wdata = ewd; v.exp_waddr = ewa; v.exp_cid = eid;
    v.exp_count = ecnt; v.exp_full = efull; v.exp_empty = eempty; v.exp_ready = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] wd,
                       input logic [4:0] wa, input logic [2:0] id, input logic wr);
    flush = fl; bus.in_valid = iv; bus.in_wdata = wd; bus.in_waddr = wa;
    bus.in_commit_id = id; bus.wb_ready = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"},  32'(full), 32'd0);
    chk({tag, ".we"},    32'(bus.reg_we), 32'd0);
    chk({tag, ".data"},  bus.reg_wdata, 32'd0);
    chk({tag, ".addr"},  32'(bus.reg_waddr), 32'd0);
    chk({tag, ".cid"},   32'(bus.commit_id), 32'd0);
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);

    // Fill to full, refuse push-while-full with a concurrent pop, then drain in order.
    tbl[0] = mk(0, 1, 32'hA1, 5'd1, 3'd1, 0,  0, 32'h00, 5'd0, 3'd0, 0, 0, 1, 1);
    tbl[1] = mk(0, 1, 32'hA2, 5'd2, 3'd2, 0,  1, 32'hA1, 5'd1, 3'd1, 1, 0, 0, 1);
    tbl[2] = mk(0, 1, 32'hA3, 5'd3, 3'd3, 0,  1, 32'hA1, 5'd1, 3'd1, 2, 0, 0, 1);
    tbl[3] = mk(0, 1, 32'hA4, 5'd0, 3'd4, 0,  1, 32'hA1, 5'd1, 3'd1, 3, 0, 0, 1);
    tbl[4] = mk(0, 1, 32'h55, 5'd9, 3'd5, 0,  1, 32'hA1, 5'd1, 3'd1, 4, 1, 0, 0);
    tbl[5] = mk(0, 1, 32'h55, 5'd9, 3'd5, 1,  1, 32'hA1, 5'd1, 3'd1, 4, 1, 0, 0);
    tbl[6] = mk(0, 0, 32'h00, 5'd0, 3'd0, 1,  1, 32'hA2, 5'd2, 3'd2, 3, 0, 0, 1);
    tbl[7] = mk(0, 0, 32'h00, 5'd0, 3'd0, 1,  1, 32'hA3, 5'd3, 3'd3, 2, 0, 0, 1);
    tbl[8] = mk(0, 0, 32'h00, 5'd0, 3'd0, 1,  1, 32'hA4, 5'd0, 3'd4, 1, 0, 0, 1);
    tbl[9] = mk(0, 0, 32'h00, 5'd0, 3'd0, 0,  0, 32'h00, 5'd0, 3'd0, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    tick();

`ifndef WB_FIFO_BYPASS_EN
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].flush, tbl[i].in_valid, tbl[i].wdata, tbl[i].waddr, tbl[i].cid, tbl[i].wb_ready);
      #1;
      $display("[TB] vec %0d: in_valid=%0b wb_ready=%0b -> we=%0b cid=%0d data=%0h count=%0d",
               i, tbl[i].in_valid, tbl[i].wb_ready, bus.reg_we, bus.commit_id, bus.reg_wdata, count);
      chk($sformatf("vec%0d.we", i),    32'(bus.reg_we),    32'(tbl[i].exp_we));
      chk($sformatf("vec%0d.data", i),  bus.reg_wdata,      tbl[i].exp_wdata);
      chk($sformatf("vec%0d.addr", i),  32'(bus.reg_waddr), 32'(tbl[i].exp_waddr));
      chk($sformatf("vec%0d.cid", i),   32'(bus.commit_id), 32'(tbl[i].exp_cid));
      chk($sformatf("vec%0d.count", i), 32'(count),         32'(tbl[i].exp_count));
      chk($sformatf("vec%0d.full", i),  32'(full),          32'(tbl[i].exp_full));
      chk($sformatf("vec%0d.empty", i), 32'(empty),         32'(tbl[i].exp_empty));
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready),  32'(tbl[i].exp_ready));
      tick();
    end

    // Streaming: 12 pushes with wb_ready held high; each ID surfaces one cycle after its push.
    for (int k = 0; k <= 12; k++) begin
      drive(1'b0, k < 12, 32'h100 + 32'(k), 5'(k), 3'(k % 8), 1'b1);
      #1;
      $display("[TB] stream %0d: we=%0b cid=%0d count=%0d", k, bus.reg_we, bus.commit_id, count);
      if (k == 0) begin
        chk("stream0.we", 32'(bus.reg_we), 32'd0);
      end else begin
        chk($sformatf("stream%0d.we", k),    32'(bus.reg_we),    32'd1);
        chk($sformatf("stream%0d.cid", k),   32'(bus.commit_id), 32'((k - 1) % 8));
        chk($sformatf("stream%0d.data", k),  bus.reg_wdata,      32'h100 + 32'(k - 1));
        chk($sformatf("stream%0d.count", k), 32'(count),         32'd1);
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    #1;
    chk_idle("stream_end");
    tick();
`endif

    // Flush with two entries held, a concurrent push and a concurrent pop.
    drive(1'b0, 1'b1, 32'h66, 5'd6, 3'd6, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h77, 5'd7, 3'd7, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h33, 5'd3, 3'd3, 1'b1);
    #1;
    $display("[TB] flush cycle: we=%0b cid=%0d count=%0d ready=%0b", bus.reg_we, bus.commit_id, count, bus.in_ready);
    chk("flush.we",    32'(bus.reg_we),    32'd1);
    chk("flush.cid",   32'(bus.commit_id), 32'd6);
    chk("flush.count", 32'(count),         32'd2);
    chk("flush.ready", 32'(bus.in_ready),  32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    #1;
    chk_idle("post_flush");
    tick();
    chk_idle("post_flush2");

    // Asynchronous reset mid-cycle with three entries held.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'hC0 + 32'(k), 5'(k + 1), 3'(k + 1), 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    #1;
    chk("prerst.count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async reset: count=%0d empty=%0b we=%0b", count, empty, bus.reg_we);
    chk_idle("async_rst");
    tick();
    rst = 1'b0;
    #1;
    chk_idle("after_rst");
    tick();

`ifdef WB_FIFO_BYPASS_EN
    // Bypass taken: retires in the same cycle, nothing stored.
    drive(1'b0, 1'b1, 32'hBEEF, 5'd5, 3'd5, 1'b1);
    #1;
    $display("[TB] bypass take: we=%0b cid=%0d data=%0h", bus.reg_we, bus.commit_id, bus.reg_wdata);
    chk("byp.we",    32'(bus.reg_we),    32'd1);
    chk("byp.cid",   32'(bus.commit_id), 32'd5);
    chk("byp.data",  bus.reg_wdata,      32'hBEEF);
    chk("byp.count", 32'(count),         32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    #1;
    chk("byp.after_count", 32'(count), 32'd0);
    // Bypass not taken: stored and held.
    drive(1'b0, 1'b1, 32'hBEEF, 5'd5, 3'd5, 1'b0);
    #1;
    chk("bypst.we", 32'(bus.reg_we), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 5'd0, 3'd0, 1'b0);
    #1;
    $display("[TB] bypass held: we=%0b cid=%0d count=%0d", bus.reg_we, bus.commit_id, count);
    chk("bypst.count", 32'(count),         32'd1);
    chk("bypst.hwe",   32'(bus.reg_we),    32'd1);
    chk("bypst.cid",   32'(bus.commit_id), 32'd5);
    chk("bypst.data",  bus.reg_wdata,      32'hBEEF);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    #1;
    chk_idle("bypst.drained");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
